// File: rtl/warp_issue_scheduler_if.sv
// Issue scheduler bundle: warp launch/completion, issue offer,
// retire feedback and LSU completion, plus status flags.
interface warp_issue_scheduler_if #(
    parameter int NUM_WARPS             = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8
);
    localparam int WID = ($clog2(NUM_WARPS) > 1) ? $clog2(NUM_WARPS) : 1;

    logic [NUM_WARPS-1:0]             warp_start;
    logic [NUM_WARPS-1:0]             warp_done;
    logic                             issue_valid;
    logic [WID-1:0]                   issue_warp;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] issue_pc;
    logic                             issue_ready;
    logic                             retire_valid;
    logic [WID-1:0]                   retire_warp;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] retire_next_pc;
    logic                             retire_mem;
    logic                             retire_ret;
    logic [NUM_WARPS-1:0]             mem_done;
    logic                             busy;
    logic                             protocol_err;

    modport slave (
        input  warp_start, issue_ready, retire_valid, retire_warp,
        input  retire_next_pc, retire_mem, retire_ret, mem_done,
        output warp_done, issue_valid, issue_warp, issue_pc,
        output busy, protocol_err
    );

    modport master (
        output warp_start, issue_ready, retire_valid, retire_warp,
        output retire_next_pc, retire_mem, retire_ret, mem_done,
        input  warp_done, issue_valid, issue_warp, issue_pc,
        input  busy, protocol_err
    );
endinterface

// File: rtl/warp_issue_scheduler.sv
// Round-robin warp issue scheduler: one instruction in flight per
// warp, shared issue path, retire/mem feedback drives warp state.
module warp_issue_scheduler #(
    parameter int NUM_WARPS             = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    warp_issue_scheduler_if.slave bus
);
    localparam int WID = ($clog2(NUM_WARPS) > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int PW  = PROGRAM_MEM_ADDR_BITS;

    typedef enum logic [2:0] {
        W_IDLE,
        W_READY,
        W_ISSUED,
        W_WAIT_MEM,
        W_DONE
    } wstate_e;

    wstate_e              st_q [NUM_WARPS];
    wstate_e              st_d [NUM_WARPS];
    logic [PW-1:0]        pc_q [NUM_WARPS];
    logic [PW-1:0]        pc_d [NUM_WARPS];
    logic [WID-1:0]       rr_q, rr_d;
    logic [NUM_WARPS-1:0] done_q, done_d;
    logic                 err_q, err_d;

    logic [NUM_WARPS-1:0] rdy, act;
    logic [WID-1:0]       sel;
    logic                 found;
    logic                 fire;
    int                   j;

    // Per-warp eligibility and activity vectors
    always_comb begin
        rdy = '0;
        act = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            rdy[w] = (st_q[w] == W_READY);
            act[w] = (st_q[w] == W_READY) || (st_q[w] == W_ISSUED) ||
                     (st_q[w] == W_WAIT_MEM);
        end
    end

    // First READY warp searching upward from rr_q, wrapping at NUM_WARPS
    always_comb begin
        found = 1'b0;
        sel   = rr_q;
        j     = 0;
        for (int k = 0; k < NUM_WARPS; k++) begin
            j = (int'(rr_q) + k) % NUM_WARPS;
            if (!found && rdy[j]) begin
                found = 1'b1;
                sel   = WID'(j);
            end
        end
    end

    assign fire = found && bus.issue_ready;

    // Next-state: launch, issue, retire and mem completion per warp
    always_comb begin
        st_d   = st_q;
        pc_d   = pc_q;
        rr_d   = rr_q;
        done_d = done_q;
        err_d  = err_q;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (bus.warp_start[w] &&
                (st_q[w] == W_IDLE || st_q[w] == W_DONE)) begin
                st_d[w]   = W_READY;
                pc_d[w]   = '0;
                done_d[w] = 1'b0;
            end
            if (fire && sel == WID'(w)) begin
                st_d[w] = W_ISSUED;
            end
            if (bus.mem_done[w] && st_q[w] == W_WAIT_MEM) begin
                st_d[w] = W_READY;
            end
            if (bus.retire_valid && bus.retire_warp == WID'(w)) begin
                if (st_q[w] == W_ISSUED) begin
                    if (bus.retire_ret) begin
                        st_d[w]   = W_DONE;
                        done_d[w] = 1'b1;
                    end else begin
                        pc_d[w] = bus.retire_next_pc;
                        st_d[w] = bus.retire_mem ? W_WAIT_MEM : W_READY;
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
        end
        if (bus.retire_valid && int'(bus.retire_warp) >= NUM_WARPS) begin
            err_d = 1'b1;
        end
        if (fire) begin
            rr_d = (int'(sel) == NUM_WARPS - 1) ? '0 : sel + WID'(1);
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                st_q[w] <= W_IDLE;
                pc_q[w] <= '0;
            end
            rr_q   <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            pc_q   <= pc_d;
            rr_q   <= rr_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign bus.issue_valid  = found;
    assign bus.issue_warp   = sel;
    assign bus.issue_pc     = pc_q[sel];
    assign bus.busy         = |act;
    assign bus.warp_done    = done_q;
    assign bus.protocol_err = err_q;
endmodule

// File: doc/warp_issue_scheduler.md
WARP_ISSUE_SCHEDULER -- requirements
Module: warp_issue_scheduler

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, meaning the number of warp contexts sharing one decode/ALU issue path (legal values 2..8).
REQ-002 SHALL have parameter PROGRAM_MEM_ADDR_BITS, default 8, meaning the PC width.
REQ-003 SHALL define WID = max(1, $clog2(NUM_WARPS)) as the width of the warp index.
REQ-004 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  is an asynchronous, active-low reset (asserted when 0).
REQ-006 warp_start  input  NUM_WARPS  is a per-warp launch pulse.
REQ-007 warp_done  output  NUM_WARPS  is a per-warp sticky completion flag.
REQ-008 issue_valid  output  1  indicates that an eligible warp is offered for issue.
REQ-009 issue_warp  output  WID  is the index of the offered warp.
REQ-010 issue_pc  output  PROGRAM_MEM_ADDR_BITS  is the PC of the offered warp.
REQ-011 issue_ready  input  1  indicates that the shared pipeline accepts the offer.
REQ-012 retire_valid  input  1  indicates that an instruction retires this cycle.
REQ-013 retire_warp  input  WID  is the index of the retiring warp.
REQ-014 retire_next_pc  input  PROGRAM_MEM_ADDR_BITS  is the next PC of the retiring warp.
REQ-015 retire_mem  input  1  indicates that the retiring instruction was a LDR/STR.
REQ-016 retire_ret  input  1  indicates that the retiring instruction was a RET.
REQ-017 mem_done  input  NUM_WARPS  is a per-warp pulse signalling that all LSUs of that warp have returned to IDLE.
REQ-018 busy  output  1  is high when any warp is in READY, ISSUED or WAIT_MEM.
REQ-019 protocol_err  output  1  is a sticky illegal-retire flag.

Function
REQ-020 SHALL keep, per warp, a state register (IDLE, READY, ISSUED, WAIT_MEM, DONE) and a PC register.
REQ-021 SHALL keep one round-robin pointer rr_ptr (WID bits).
REQ-022 SHALL transition a warp IDLE/DONE -> READY on warp_start[w], clear its PC to 0 and clear warp_done[w].
REQ-023 SHALL ignore warp_start[w] while the warp is in READY, ISSUED or WAIT_MEM.
REQ-024 SHALL drive issue_valid combinationally high when any warp is READY.
REQ-025 SHALL select as issue_warp the first READY warp found searching upward from rr_ptr, with wrap-around from NUM_WARPS-1 to 0.
REQ-026 SHALL drive issue_pc with that warp's PC.
REQ-027 SHALL hold issue_warp and issue_pc stable while issue_valid=1 and issue_ready=0, unless a higher-priority warp becomes READY.
REQ-028 On issue_valid && issue_ready, SHALL move the selected warp to ISSUED and set rr_ptr to (issue_warp+1) mod NUM_WARPS.
REQ-029 SHALL allow at most one instruction in flight per warp; a warp in ISSUED or WAIT_MEM is never offered.
REQ-030 On retire_valid for a warp in ISSUED with retire_ret=1, SHALL move the warp to DONE and set warp_done[w]; retire_mem is ignored in this case.
REQ-031 On retire_valid for a warp in ISSUED with retire_ret=0 and retire_mem=1, SHALL set PC to retire_next_pc and move the warp to WAIT_MEM.
REQ-032 On retire_valid for a warp in ISSUED with retire_ret=0 and retire_mem=0, SHALL set PC to retire_next_pc and move the warp to READY.
REQ-033 SHALL move a warp WAIT_MEM -> READY on mem_done[w]; mem_done in any other state is ignored.
REQ-034 SHALL make a warp re-entering READY eligible for issue one cycle after its retire or mem_done edge, never in the same cycle.
REQ-035 SHALL apply an issue of warp A and a retire/mem_done of warp B in the same cycle both, independently.
REQ-036 SHALL leave state unchanged on retire_valid for a warp not in ISSUED, and set protocol_err.
REQ-037 SHALL truncate the PC to PROGRAM_MEM_ADDR_BITS; retire_next_pc = 2^PROGRAM_MEM_ADDR_BITS-1 followed by +1 from the pipeline wraps to 0, with no error.

Reset
REQ-038 When reset=0, SHALL asynchronously force all warps to IDLE, all PCs to 0, rr_ptr=0, warp_done=0, protocol_err=0, issue_valid=0 and busy=0.
REQ-039 Reset asserted mid-operation SHALL drop any in-flight state; no retire is honoured until release.
REQ-040 SHALL act on inputs from the first rising clk edge after reset rises.

Verification
REQ-041 NUM_WARPS=4: start warps 0-3, issue_ready=1, retire each one cycle after issue with next_pc=pc+1 -> issue_warp sequence 0,1,2,3,0,...; each warp's issue_pc increments per visit.
REQ-042 Warp 1 retires with retire_mem=1 -> warp 1 skipped (order 0,2,3,0,2,...) until mem_done[1]; warp 1 offered again from the following cycle.
REQ-043 Warp 2 retires with retire_ret=1 -> warp_done[2]=1 and is never offered again; a later warp_start[2] pulse clears warp_done[2] and re-offers it with issue_pc=0.
REQ-044 issue_ready=0 for 5 cycles with warps 0 and 3 READY and rr_ptr=3 -> issue_valid=1, issue_warp=3 stable; on accept, rr_ptr=0.
REQ-045 retire_valid for an IDLE warp -> protocol_err=1 and sticky; states unchanged; reset low mid-run -> all outputs 0 immediately, without waiting for clk.
